// File: rtl/defines.sv
// Shared types for the ID/EX boundary: datapath widths, forwarding selects
// and the packed bundle held in the ID/EX pipeline register.
package defines;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;

   typedef enum logic [1:0] {
      FW_NONE    = 2'd0,
      FW_MEM_ALU = 2'd1,
      FW_WB_DATA = 2'd2
   } fw_sel_e;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [4:0]        rs1_addr;
      logic [4:0]        rs2_addr;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [4:0]        rd_addr;
      logic              reg_write;
      logic              mem_read;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational forwarding mux for one EX operand; unknown selects fall back
// to the value stored in the pipeline register.
module operand_fwd_mux
   import defines::*;
(
   input  fw_sel_e         sel_i,
   input  logic [XLEN-1:0] reg_data_i,
   input  logic [XLEN-1:0] mem_alu_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] val_o
);

   always_comb begin
      val_o = reg_data_i;
      case (sel_i)
         FW_MEM_ALU: val_o = mem_alu_i;
         FW_WB_DATA: val_o = wb_data_i;
         default:    val_o = reg_data_i;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion
// and re-capture of forwarded operands while EX is held.
module id_ex_stage
   import defines::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [4:0]        id_rd_addr_i,
   input  logic              id_RegWrite_i,
   input  logic              id_MemRead_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   input  logic              ex_stall_i,
   input  logic              flush_i,
   input  fw_sel_e           forwardA_i,
   input  fw_sel_e           forwardB_i,
   input  logic [XLEN-1:0]   mem_alu_result_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic              id_stall_o,
   output logic              EX_valid_o,
   output logic [XLEN-1:0]   EX_pc_o,
   output logic [XLEN-1:0]   EX_imm_o,
   output logic [4:0]        EX_rd_addr_o,
   output logic              EX_RegWrite_o,
   output logic              EX_MemRead_o,
   output logic [CTRL_W-1:0] EX_ctrl_o,
   output logic [4:0]        EX_rs1_addr_o,
   output logic [4:0]        EX_rs2_addr_o,
   output logic [XLEN-1:0]   EX_rs1_val_o,
   output logic [XLEN-1:0]   EX_rs2_val_o
);

   id_ex_t ex_q;
   id_ex_t ex_d;
   logic   load_use;

   fw_sel_e         fw_sel   [2];
   logic [XLEN-1:0] reg_data [2];
   logic [XLEN-1:0] fwd_val  [2];

   assign fw_sel[0]   = forwardA_i;
   assign fw_sel[1]   = forwardB_i;
   assign reg_data[0] = ex_q.rs1_data;
   assign reg_data[1] = ex_q.rs2_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         operand_fwd_mux u_mux (
            .sel_i      (fw_sel[gi]),
            .reg_data_i (reg_data[gi]),
            .mem_alu_i  (mem_alu_result_i),
            .wb_data_i  (wb_data_i),
            .val_o      (fwd_val[gi])
         );
      end
   endgenerate

   assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != 5'd0) & id_valid_i &
                     ((ex_q.rd_addr == id_rs1_addr_i) | (ex_q.rd_addr == id_rs2_addr_i));

   // Gating with rst keeps the stall low even if ex_stall_i is raised during reset.
   assign id_stall_o = (ex_stall_i | load_use) & ~flush_i & ~rst;

   always_comb begin
      ex_d = ex_q;
      if (flush_i) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
         ex_d.mem_read  = 1'b0;
      end else if (ex_stall_i) begin
         // Capture forwarded values so a draining MEM/WB cannot take them away.
         ex_d.rs1_data = fwd_val[0];
         ex_d.rs2_data = fwd_val[1];
      end else if (load_use) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
         ex_d.mem_read  = 1'b0;
         ex_d.rs1_addr  = 5'd0;
         ex_d.rs2_addr  = 5'd0;
      end else begin
         ex_d.valid     = id_valid_i;
         ex_d.pc        = id_pc_i;
         ex_d.rs1_addr  = id_rs1_addr_i;
         ex_d.rs2_addr  = id_rs2_addr_i;
         ex_d.rs1_data  = id_rs1_data_i;
         ex_d.rs2_data  = id_rs2_data_i;
         ex_d.imm       = id_imm_i;
         ex_d.rd_addr   = id_rd_addr_i;
         ex_d.reg_write = id_RegWrite_i & id_valid_i;
         ex_d.mem_read  = id_MemRead_i & id_valid_i;
         ex_d.ctrl      = id_ctrl_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign EX_valid_o    = ex_q.valid;
   assign EX_pc_o       = ex_q.pc;
   assign EX_imm_o      = ex_q.imm;
   assign EX_rd_addr_o  = ex_q.rd_addr;
   assign EX_RegWrite_o = ex_q.reg_write;
   assign EX_MemRead_o  = ex_q.mem_read;
   assign EX_ctrl_o     = ex_q.ctrl;
   assign EX_rs1_addr_o = ex_q.rs1_addr;
   assign EX_rs2_addr_o = ex_q.rs2_addr;
   assign EX_rs1_val_o  = fwd_val[0];
   assign EX_rs2_val_o  = fwd_val[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, advance, forwarding, load-use,
// stall capture, flush priority and reset in the middle of a stall.
module tb_id_ex_stage;
   import defines::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid_i;
   logic [XLEN-1:0]   id_pc_i;
   logic [4:0]        id_rs1_addr_i, id_rs2_addr_i;
   logic [XLEN-1:0]   id_rs1_data_i, id_rs2_data_i;
   logic [XLEN-1:0]   id_imm_i;
   logic [4:0]        id_rd_addr_i;
   logic              id_RegWrite_i, id_MemRead_i;
   logic [CTRL_W-1:0] id_ctrl_i;
   logic              ex_stall_i, flush_i;
   fw_sel_e           forwardA_i, forwardB_i;
   logic [XLEN-1:0]   mem_alu_result_i, wb_data_i;
   logic              id_stall_o;
   logic              EX_valid_o;
   logic [XLEN-1:0]   EX_pc_o, EX_imm_o;
   logic [4:0]        EX_rd_addr_o;
   logic              EX_RegWrite_o, EX_MemRead_o;
   logic [CTRL_W-1:0] EX_ctrl_o;
   logic [4:0]        EX_rs1_addr_o, EX_rs2_addr_o;
   logic [XLEN-1:0]   EX_rs1_val_o, EX_rs2_val_o;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk              (clk),
      .rst              (rst),
      .id_valid_i       (id_valid_i),
      .id_pc_i          (id_pc_i),
      .id_rs1_addr_i    (id_rs1_addr_i),
      .id_rs2_addr_i    (id_rs2_addr_i),
      .id_rs1_data_i    (id_rs1_data_i),
      .id_rs2_data_i    (id_rs2_data_i),
      .id_imm_i         (id_imm_i),
      .id_rd_addr_i     (id_rd_addr_i),
      .id_RegWrite_i    (id_RegWrite_i),
      .id_MemRead_i     (id_MemRead_i),
      .id_ctrl_i        (id_ctrl_i),
      .ex_stall_i       (ex_stall_i),
      .flush_i          (flush_i),
      .forwardA_i       (forwardA_i),
      .forwardB_i       (forwardB_i),
      .mem_alu_result_i (mem_alu_result_i),
      .wb_data_i        (wb_data_i),
      .id_stall_o       (id_stall_o),
      .EX_valid_o       (EX_valid_o),
      .EX_pc_o          (EX_pc_o),
      .EX_imm_o         (EX_imm_o),
      .EX_rd_addr_o     (EX_rd_addr_o),
      .EX_RegWrite_o    (EX_RegWrite_o),
      .EX_MemRead_o     (EX_MemRead_o),
      .EX_ctrl_o        (EX_ctrl_o),
      .EX_rs1_addr_o    (EX_rs1_addr_o),
      .EX_rs2_addr_o    (EX_rs2_addr_o),
      .EX_rs1_val_o     (EX_rs1_val_o),
      .EX_rs2_val_o     (EX_rs2_val_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %-22s obs=%h exp=%h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                           input logic rw, input logic mr);
      id_valid_i    = 1'b1;
      id_pc_i       = pc;
      id_rs1_addr_i = rs1;
      id_rs2_addr_i = rs2;
      id_rs1_data_i = d1;
      id_rs2_data_i = d2;
      id_rd_addr_i  = rd;
      id_RegWrite_i = rw;
      id_MemRead_i  = mr;
   endtask

   initial begin
      rst = 1'b1;
      id_valid_i = 1'b0; id_pc_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
      id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0; id_rd_addr_i = '0;
      id_RegWrite_i = 1'b0; id_MemRead_i = 1'b0; id_ctrl_i = '0;
      ex_stall_i = 1'b1; flush_i = 1'b0;
      forwardA_i = FW_NONE; forwardB_i = FW_NONE;
      mem_alu_result_i = '0; wb_data_i = '0;

      // Reset, with ex_stall_i high to show the stall is suppressed
      tick(); tick();
      chk("rst_valid", {31'd0, EX_valid_o}, 32'd0);
      chk("rst_pc", EX_pc_o, 32'd0);
      chk("rst_id_stall", {31'd0, id_stall_o}, 32'd0);
      ex_stall_i = 1'b0;
      @(negedge clk); rst = 1'b0;

      // Plain advance: add x3,x1,x2 at 0x100
      id_instr(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      id_imm_i = 32'h0000_0010; id_ctrl_i = 16'h00A5;
      tick();
      chk("adv_pc", EX_pc_o, 32'h100);
      chk("adv_rs1_val", EX_rs1_val_o, 32'd5);
      chk("adv_rs2_val", EX_rs2_val_o, 32'd7);
      chk("adv_rd", {27'd0, EX_rd_addr_o}, 32'd3);
      chk("adv_valid_rw", {30'd0, EX_valid_o, EX_RegWrite_o}, 32'd3);
      chk("adv_imm", EX_imm_o, 32'h10);
      chk("adv_ctrl", {16'd0, EX_ctrl_o}, 32'h00A5);

      // Same-cycle forwarding
      forwardA_i = FW_MEM_ALU; mem_alu_result_i = 32'hAA;
      forwardB_i = FW_WB_DATA; wb_data_i = 32'hBB;
      #1;
      chk("fwd_a_mem", EX_rs1_val_o, 32'hAA);
      chk("fwd_b_wb", EX_rs2_val_o, 32'hBB);
      forwardA_i = fw_sel_e'(2'b11);
      #1;
      chk("fwd_a_unknown", EX_rs1_val_o, 32'd5);
      forwardA_i = FW_NONE; forwardB_i = FW_NONE;

      // Load-use: lw x5 then a consumer of x5 in rs2
      id_instr(32'h104, 5'd1, 5'd0, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1);
      tick();
      chk("lw_in_ex_memread", {31'd0, EX_MemRead_o}, 32'd1);
      id_instr(32'h108, 5'd4, 5'd5, 32'd9, 32'd0, 5'd6, 1'b1, 1'b0);
      #1;
      chk("lu_stall", {31'd0, id_stall_o}, 32'd1);
      tick();
      chk("lu_bubble_flags", {29'd0, EX_valid_o, EX_RegWrite_o, EX_MemRead_o}, 32'd0);
      chk("lu_bubble_rs", {22'd0, EX_rs1_addr_o, EX_rs2_addr_o}, 32'd0);
      chk("lu_stall_released", {31'd0, id_stall_o}, 32'd0);
      tick();
      chk("lu_consumer_pc", EX_pc_o, 32'h108);
      chk("lu_consumer_rs2", {27'd0, EX_rs2_addr_o}, 32'd5);
      chk("lu_consumer_valid", {31'd0, EX_valid_o}, 32'd1);

      // Load to x0 never stalls
      id_instr(32'h10C, 5'd1, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
      tick();
      id_instr(32'h110, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0);
      #1;
      chk("x0_no_stall", {31'd0, id_stall_o}, 32'd0);
      tick();
      chk("x0_consumer_pc", EX_pc_o, 32'h110);

      // Stall capture over 3 stalled edges
      id_instr(32'h200, 5'd7, 5'd8, 32'h11, 32'h22, 5'd9, 1'b1, 1'b0);
      tick();
      id_instr(32'h204, 5'd10, 5'd11, 32'h33, 32'h44, 5'd12, 1'b1, 1'b0);
      ex_stall_i = 1'b1; forwardA_i = FW_WB_DATA; wb_data_i = 32'h1234;
      #1;
      chk("st_id_stall", {31'd0, id_stall_o}, 32'd1);
      chk("st_c1_rs1", EX_rs1_val_o, 32'h1234);
      tick();
      forwardA_i = FW_NONE; wb_data_i = 32'hDEAD;
      #1;
      chk("st_c2_rs1", EX_rs1_val_o, 32'h1234);
      chk("st_c2_pc", EX_pc_o, 32'h200);
      tick();
      chk("st_c3_rs1", EX_rs1_val_o, 32'h1234);
      chk("st_c3_rs2", EX_rs2_val_o, 32'h22);
      tick();
      chk("st_end_pc", EX_pc_o, 32'h200);
      ex_stall_i = 1'b0;
      tick();
      chk("st_adv_pc", EX_pc_o, 32'h204);
      chk("st_adv_rs1", EX_rs1_val_o, 32'h33);

      // Flush beats ex_stall and load_use together
      id_instr(32'h300, 5'd1, 5'd2, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1);
      tick();
      id_instr(32'h304, 5'd5, 5'd0, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0);
      ex_stall_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("fl_id_stall", {31'd0, id_stall_o}, 32'd0);
      tick();
      chk("fl_flags", {29'd0, EX_valid_o, EX_RegWrite_o, EX_MemRead_o}, 32'd0);
      ex_stall_i = 1'b0; flush_i = 1'b0;

      // Reset asserted mid-stall, away from the clock edge
      id_instr(32'h400, 5'd3, 5'd4, 32'h55, 32'h66, 5'd8, 1'b1, 1'b0);
      tick();
      chk("pre_rst_pc", EX_pc_o, 32'h400);
      ex_stall_i = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, EX_valid_o}, 32'd0);
      chk("mid_rst_pc", EX_pc_o, 32'd0);
      chk("mid_rst_rs1", EX_rs1_val_o, 32'd0);
      chk("mid_rst_id_stall", {31'd0, id_stall_o}, 32'd0);
      @(negedge clk); rst = 1'b0; ex_stall_i = 1'b0; id_valid_i = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
